mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: width of address and data buses.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive data grants allowed while fetch waits.
REQ-003 Parameter TIMEOUT_CYC, default 16: maximum BUSY cycles before forced completion.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  fetch request; held with i_addr stable until i_ack.
REQ-007 i_addr  in  DATA_W  fetch byte address.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 i_rdata  out  DATA_W  fetch data; valid while i_ack=1.
REQ-010 d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack.
REQ-011 d_we  in  1  data write (1) or read (0).
REQ-012 d_addr, d_wdata  in  DATA_W each  data address and write data.
REQ-013 d_ack  out  1  one-cycle data completion pulse.
REQ-014 d_rdata  out  DATA_W  read data; valid while d_ack=1.
REQ-015 mem_req, mem_we  out  1 each  shared-port request and write enable.
REQ-016 mem_addr, mem_wdata  out  DATA_W each  shared-port address and write data.
REQ-017 mem_rdata  in  DATA_W; mem_ready  in  1  port completion, sampled only in BUSY.
REQ-018 stall_if, stall_mem  out  1 each  pipeline stall requests.
REQ-019 timeout_err  out  1  sticky error flag.

Function
REQ-020 FSM states SHALL be IDLE, BUSY and RESP.
REQ-021 IDLE: if any request is present, the FSM SHALL grant one requester, latch its address, write enable and write data into port registers, and move to BUSY.
REQ-022 Grant priority SHALL be data over fetch, except fetch SHALL win when starve_cnt==STARVE_LIMIT and both requests are present.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on a data grant with i_req=1, and clear to 0 on any fetch grant.
REQ-024 BUSY: mem_req=1, with port outputs driven from the latched registers; fetch grants drive mem_we=0.
REQ-025 In BUSY, mem_ready=1 SHALL register mem_rdata and move the FSM to RESP.
REQ-026 A BUSY cycle counter SHALL clear on BUSY entry.
REQ-027 If the counter reaches TIMEOUT_CYC-1 with mem_ready=0, the FSM SHALL move to RESP with rdata=0 and set timeout_err.
REQ-028 RESP: exactly the granted requester's ack SHALL be 1 for one cycle, with registered rdata; the FSM then returns to IDLE.
REQ-029 Requesters SHALL drop or replace their request at the clock edge that ends the ack cycle; requests SHALL be re-evaluated only in IDLE.
REQ-030 Minimum latency with a zero-wait port: request in IDLE cycle N, mem_req in N+1, ack in N+2.
REQ-031 Each completion SHALL be followed by one IDLE cycle.
REQ-032 stall_if = i_req & ~i_ack and stall_mem = d_req & ~d_ack, both combinational.
REQ-033 mem_req SHALL be 0 outside BUSY; the ungranted ack SHALL never assert.

Reset
REQ-034 reset=0 at any time, including mid-BUSY, SHALL immediately force IDLE.
REQ-035 The same reset SHALL clear starve_cnt, the timeout counter, timeout_err, all latched registers, every ack, mem_req and mem_we.
REQ-036 An interrupted memory transaction SHALL NOT be acknowledged after reset release.

Structure
REQ-037 Shared package mem_arb_pkg SHALL hold the state encoding and grant identifiers (GNT_I, GNT_D).
REQ-038 Sub-module arb_timeout_counter SHALL implement the BUSY cycle counter and timeout detect.

Verification
REQ-039 d_req only, write 0xDEADBEEF to 0x40, zero-wait port -> mem_we=1 and mem_addr=0x40 in cycle N+1, d_ack in N+2.
REQ-040 d_req and i_req held continuously -> fifth grant goes to fetch (STARVE_LIMIT=4), after which starve_cnt=0.
REQ-041 i_req at 0x100, mem_ready delayed 3 cycles, mem_rdata=0x12345678 -> i_ack in N+5 with i_rdata=0x12345678; stall_if high until then.
REQ-042 mem_ready never asserts -> ack 16 cycles after BUSY entry with rdata=0; timeout_err=1 and stays 1.
REQ-043 reset pulled low in BUSY -> mem_req=0 immediately, no ack after release, next request served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state encoding and grant identifiers for mem_port_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;
endpackage

// File: rtl/arb_timeout_counter.sv
// arb_timeout_counter: counts BUSY cycles and flags when the port has run out of time
// Ports: clk, reset (async active-low), busy_i (FSM is in BUSY), expired_o (last allowed BUSY cycle)
module arb_timeout_counter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic busy_i,
    output logic expired_o
);
    localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] cnt_q;
    // Held at zero outside BUSY, so every BUSY entry starts counting from 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= busy_i ? cnt_q + 1'b1 : '0;
    end
    assign expired_o = busy_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data requester
// Ports: clk, reset (async active-low); fetch i_req/i_addr -> i_ack/i_rdata;
//        data d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata; shared port mem_req/mem_we/
//        mem_addr/mem_wdata, mem_rdata/mem_ready; stall_if/stall_mem; sticky timeout_err
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    state_e            state_q;
    gnt_e              gnt_q;
    gnt_e              gnt_d;
    logic [SW-1:0]     starve_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              mem_req_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic              err_q;
    logic              expired;
    logic              starved;
    arb_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .busy_i   (state_q == BUSY),
        .expired_o(expired)
    );
    assign starved = starve_q == SW'(STARVE_LIMIT);
    // Data normally wins; a fetch that has waited STARVE_LIMIT data grants goes first
    assign gnt_d   = (i_req && (!d_req || starved)) ? GNT_I : GNT_D;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            starve_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            mem_req_q <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_req || d_req) begin
                    state_q   <= BUSY;
                    gnt_q     <= gnt_d;
                    mem_req_q <= 1'b1;
                    addr_q    <= gnt_d == GNT_D ? d_addr : i_addr;
                    wdata_q   <= gnt_d == GNT_D ? d_wdata : '0;
                    we_q      <= gnt_d == GNT_D && d_we;
                    starve_q  <= gnt_d == GNT_I ? '0 :
                                 (i_req && !starved) ? starve_q + 1'b1 : starve_q;
                end
                BUSY: if (mem_ready || expired) begin
                    // A ready on the final cycle still counts as a real completion
                    state_q   <= RESP;
                    mem_req_q <= 1'b0;
                    we_q      <= 1'b0;
                    rdata_q   <= mem_ready ? mem_rdata : '0;
                    err_q     <= err_q | ~mem_ready;
                    i_ack_q   <= gnt_q == GNT_I;
                    d_ack_q   <= gnt_q == GNT_D;
                end
                default: begin
                    state_q <= IDLE;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
            endcase
        end
    end
    assign mem_req     = mem_req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign i_rdata     = rdata_q;
    assign d_rdata     = rdata_q;
    assign timeout_err = err_q;
    assign stall_if    = i_req & ~i_ack_q;
    assign stall_mem   = d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ack;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem, timeout_err;

    localparam int S_MREQ = 0, S_ERR = 1, S_SIF = 2, S_SMEM = 3, S_IACK = 4, S_DACK = 5, S_MWE = 6;

    typedef struct {int cyc; logic is_d; logic [31:0] rdata;} ack_t;
    typedef struct {int cyc; logic we; logic [31:0] addr; logic [31:0] wdata; logic chk_wd;} mem_t;
    typedef struct {int cyc; int sel; logic [31:0] exp;} misc_t;

    ack_t  acks[$];
    mem_t  mems[$];
    misc_t misc[$];
    ack_t  a;
    mem_t  m;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_fail = 0;
    logic  done = 1'b0;
    logic  mem_prev = 1'b0;
    logic  exp_ack, exp_rise, rise;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sig(input int sel);
        case (sel)
            S_MREQ:  return {31'b0, mem_req};
            S_ERR:   return {31'b0, timeout_err};
            S_SIF:   return {31'b0, stall_if};
            S_SMEM:  return {31'b0, stall_mem};
            S_IACK:  return {31'b0, i_ack};
            S_DACK:  return {31'b0, d_ack};
            default: return {31'b0, mem_we};
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            S_MREQ:  return "mem_req";
            S_ERR:   return "timeout_err";
            S_SIF:   return "stall_if";
            S_SMEM:  return "stall_mem";
            S_IACK:  return "i_ack";
            S_DACK:  return "d_ack";
            default: return "mem_we";
        endcase
    endfunction

    // Monitor: sole owner of the counters; compares whatever the DUT presents this cycle
    always @(negedge clk) begin
        if (done) begin
            chk("leftover_expectations", acks.size() + mems.size() + misc.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
            $finish;
        end else begin
            for (int k = misc.size() - 1; k >= 0; k--)
                if (misc[k].cyc == cyc) begin
                    chk(sname(misc[k].sel), sig(misc[k].sel), misc[k].exp);
                    misc.delete(k);
                end
            while (acks.size() > 0 && acks[0].cyc < cyc) acks.delete(0);
            exp_ack = acks.size() > 0 && acks[0].cyc == cyc;
            chk("ack_present", {31'b0, i_ack | d_ack}, {31'b0, exp_ack});
            if (exp_ack && (i_ack | d_ack)) begin
                a = acks.pop_front();
                chk("ack_d", {31'b0, d_ack}, {31'b0, a.is_d});
                chk("ack_i", {31'b0, i_ack}, {31'b0, !a.is_d});
                chk("ack_rdata", a.is_d ? d_rdata : i_rdata, a.rdata);
            end
            while (mems.size() > 0 && mems[0].cyc < cyc) mems.delete(0);
            rise = mem_req & ~mem_prev;
            mem_prev = mem_req;
            exp_rise = mems.size() > 0 && mems[0].cyc == cyc;
            chk("mem_req_start", {31'b0, rise}, {31'b0, exp_rise});
            if (exp_rise && rise) begin
                m = mems.pop_front();
                chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                chk("mem_addr", mem_addr, m.addr);
                if (m.chk_wd) chk("mem_wdata", mem_wdata, m.wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pa(input int c, input logic is_d, input logic [31:0] rd);
        acks.push_back('{cyc: c, is_d: is_d, rdata: rd});
    endtask

    task automatic pm(input int c, input logic we, input logic [31:0] ad, input logic [31:0] wd, input logic cw);
        mems.push_back('{cyc: c, we: we, addr: ad, wdata: wd, chk_wd: cw});
    endtask

    task automatic px(input int c, input int sel, input logic [31:0] v);
        misc.push_back('{cyc: c, sel: sel, exp: v});
    endtask

    initial begin
        int n;
        reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        for (int s = 0; s <= S_MWE; s++) px(1, s, 0);
        wait_to(2);
        reset = 1'b1;
        // Zero-wait write of 0xDEADBEEF to 0x40
        wait_to(4); n = cyc;
        mem_ready = 1'b1; mem_rdata = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        pm(n + 1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
        pa(n + 2, 1'b1, 32'h0);
        px(n, S_SMEM, 1); px(n + 1, S_MREQ, 1); px(n + 2, S_MREQ, 0);
        px(n + 2, S_SMEM, 0); px(n + 3, S_MREQ, 0); px(n + 2, S_MWE, 0);
        wait_to(n + 3);
        d_req = 1'b0; d_we = 1'b0;
        // Zero-wait data read
        wait_to(8); n = cyc;
        mem_rdata = 32'hA5A50001;
        d_req = 1'b1; d_addr = 32'h80;
        pm(n + 1, 1'b0, 32'h80, 32'h0, 1'b0);
        pa(n + 2, 1'b1, 32'hA5A50001);
        wait_to(n + 3);
        d_req = 1'b0;
        // Both requesters held: four data grants then one fetch, twice
        wait_to(14); n = cyc;
        mem_rdata = 32'h55;
        d_req = 1'b1; d_addr = 32'h200; i_req = 1'b1; i_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            pm(n + 1 + 3 * k, 1'b0, (k == 4 || k == 9) ? 32'h300 : 32'h200, 32'h0, 1'b0);
            pa(n + 2 + 3 * k, !(k == 4 || k == 9), 32'h55);
        end
        px(n, S_SIF, 1); px(n + 14, S_SIF, 0); px(n + 15, S_SIF, 1);
        px(n + 2, S_SMEM, 0); px(n + 14, S_SMEM, 1);
        wait_to(n + 30);
        d_req = 1'b0; i_req = 1'b0;
        // Fetch with the port ready three cycles late
        wait_to(50); n = cyc;
        mem_ready = 1'b0; mem_rdata = 32'h12345678;
        i_req = 1'b1; i_addr = 32'h100;
        pm(n + 1, 1'b0, 32'h100, 32'h0, 1'b0);
        pa(n + 5, 1'b0, 32'h12345678);
        px(n, S_SIF, 1); px(n + 3, S_SIF, 1); px(n + 4, S_SIF, 1); px(n + 5, S_SIF, 0);
        px(n + 4, S_MREQ, 1); px(n + 5, S_MREQ, 0); px(n + 5, S_DACK, 0);
        wait_to(n + 4);
        mem_ready = 1'b1;
        wait_to(n + 5);
        mem_ready = 1'b0;
        wait_to(n + 6);
        i_req = 1'b0;
        // Port never ready: forced completion with zero data and sticky error
        wait_to(60); n = cyc;
        mem_rdata = 32'hFFFFFFFF;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        pm(n + 1, 1'b0, 32'h44, 32'h0, 1'b0);
        pa(n + 17, 1'b1, 32'h0);
        px(n + 16, S_ERR, 0); px(n + 16, S_MREQ, 1); px(n + 17, S_MREQ, 0);
        px(n + 17, S_ERR, 1); px(n + 25, S_ERR, 1);
        wait_to(n + 18);
        d_req = 1'b0;
        // Reset in the middle of BUSY, then a normal fetch
        wait_to(90); n = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'h11;
        pm(n + 1, 1'b1, 32'h60, 32'h11, 1'b1);
        px(n + 1, S_ERR, 1); px(n + 2, S_MREQ, 0); px(n + 2, S_MWE, 0);
        px(n + 2, S_ERR, 0); px(n + 5, S_MREQ, 0); px(n + 6, S_MREQ, 0);
        wait_to(n + 2);
        reset = 1'b0;
        wait_to(n + 3);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b1;
        wait_to(n + 4);
        reset = 1'b1;
        wait_to(n + 8);
        mem_rdata = 32'hCAFE0000;
        i_req = 1'b1; i_addr = 32'h180;
        pm(n + 9, 1'b0, 32'h180, 32'h0, 1'b0);
        pa(n + 10, 1'b0, 32'hCAFE0000);
        px(n + 12, S_ERR, 0);
        wait_to(n + 11);
        i_req = 1'b0;
        wait_to(n + 14);
        done = 1'b1;
    end
endmodule
